uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Serial UART transmitter that turns a parallel word into one start bit, WIDTH data bits (LSB first), an optional parity bit and one stop bit on TX_OUT. Each bit lasts `prescale` CLK cycles, so the block shares the oversampled UART clock and prescale setting of the receive path. It sits between the system-side result source (ALU/register-file response path) and the serial line, with a valid/ready handshake on the parallel side.

## Interface
- WIDTH, 8, data bits per frame
- CLK  in  1  UART oversampled clock; all state updates on rising edge
- RST  in  1  asynchronous, active-low reset
- P_DATA  in  WIDTH  word to send; captured on accept
- DATA_VALID  in  1  word request; accepted when DATA_VALID && TX_READY at a rising edge
- PAR_EN  in  1  1 = parity bit inserted; captured on accept
- PAR_TYP  in  1  0 = even, 1 = odd; captured on accept
- prescale  in  6  CLK cycles per bit; captured on accept; values 0..3 clamp to 4
- TX_READY  out  1  block can accept a word this cycle
- TX_OUT  out  1  serial line, registered, idle high
- busy  out  1  frame in progress (START..STOP)
- frame_done  out  1  one-cycle pulse on the edge that ends a stop bit

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Registers: shift data, captured PAR_EN/PAR_TYP/prescale, edge counter (6 bit, 0..prescale-1), bit counter (0..WIDTH-1).
- IDLE: TX_OUT=1, busy=0. On accept: capture inputs, edge_cnt=0 -> START.
- START: TX_OUT=0. At edge_cnt==prescale-1 -> DATA, bit_cnt=0.
- DATA: TX_OUT=data[bit_cnt]. At edge_cnt==prescale-1: if bit_cnt==WIDTH-1 -> PARITY (PAR_EN=1) or STOP (PAR_EN=0); else bit_cnt+1.
- PARITY: TX_OUT = (^data) ^ PAR_TYP.
- STOP: TX_OUT=1. At edge_cnt==prescale-1: frame_done=1; -> IDLE, or -> START with buffered word (see Configuration).
- edge_cnt resets to 0 at every bit boundary; wraps only at prescale-1, never at 63.
- Inputs changed after accept have no effect on the current frame.
- Parity computed from the captured word, not live P_DATA.

## Timing
- Reset values: TX_OUT=1, busy=0, TX_READY=1, frame_done=0, state IDLE, counters 0. Reset mid-frame forces TX_OUT=1 immediately (asynchronous) and discards frame and buffer.
- Accept at edge k: TX_OUT low and busy high from edge k (registered, visible cycle after k); start bit spans cycles k+1..k+prescale.
- Frame length: (2 + WIDTH + PAR_EN) × prescale cycles.
- busy falls and frame_done pulses on the same edge that ends the stop bit; TX_OUT stays 1.
- Without buffering, TX_READY = (state==IDLE); earliest next accept is the edge after busy falls, giving minimum one idle cycle between frames.

## Configuration
- UART_TX_HOLD_BUF_EN defined: one-entry holding buffer (P_DATA, PAR_EN, PAR_TYP, prescale). TX_READY = buffer empty. Accept while busy fills buffer. At end of stop bit with buffer full: go straight to START, no idle cycle, busy stays 1, buffer empties, frame_done still pulses. Accept in IDLE with empty buffer starts a frame directly. Simultaneous buffer drain and new accept in the same edge: new word enters buffer.
- Undefined: no buffer; TX_READY = (state==IDLE); DATA_VALID while busy ignored.

## Test plan
- Reset, prescale=8, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5 -> TX_OUT 0,1,0,1,0,0,1,0,1,0,1, 8 cycles each; busy high 88 cycles; one frame_done pulse.
- PAR_TYP=1, P_DATA=0x01, prescale=16 -> parity bit 0; PAR_TYP=0 same data -> parity bit 1.
- PAR_EN=0, P_DATA=0xFF, prescale=16 -> 160-cycle frame, no parity bit, stop directly after bit 7.
- Without macro: DATA_VALID=1 with 0x3C during busy -> ignored; line idle after frame; TX_READY=1 only in IDLE. prescale=2 -> bits last 4 cycles.
- With UART_TX_HOLD_BUF_EN: send 0x11 then 0x22 during first frame -> TX_READY low until drain; second start bit begins the cycle after first stop bit ends, busy never drops.
- RST low mid-DATA -> TX_OUT=1, busy=0, TX_READY=1 immediately; next accept sends clean frame.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, WIDTH data bits LSB first, optional parity, one stop bit.
// Define UART_TX_HOLD_BUF_EN for a one-entry holding buffer giving back-to-back frames.
module uart_tx_frame #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] P_DATA,
   input  logic             DATA_VALID,
   input  logic             PAR_EN,
   input  logic             PAR_TYP,
   input  logic [5:0]       prescale,
   output logic             TX_READY,
   output logic             TX_OUT,
   output logic             busy,
   output logic             frame_done
);
   localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e           state_q, state_d;
   logic [5:0]       edge_cnt_q, edge_cnt_d;
   logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             par_en_q, par_en_d;
   logic             par_typ_q, par_typ_d;
   logic [5:0]       presc_q, presc_d;
   logic             tx_q, tx_d;
   logic             done_q, done_d;
   logic             accept, bit_end, start_in, start_buf;
   logic [5:0]       presc_in;

   // Bit periods shorter than four cycles are not supported by the line, clamp them.
   assign presc_in = (prescale < 6'd4) ? 6'd4 : prescale;
   assign bit_end  = (edge_cnt_q == presc_q - 6'd1);
   assign accept   = DATA_VALID && TX_READY;

`ifdef UART_TX_HOLD_BUF_EN
   logic             buf_full_q, buf_full_d;
   logic [WIDTH-1:0] buf_data_q, buf_data_d;
   logic             buf_par_en_q, buf_par_en_d;
   logic             buf_par_typ_q, buf_par_typ_d;
   logic [5:0]       buf_presc_q, buf_presc_d;

   assign TX_READY = !buf_full_q;
`else
   assign TX_READY = (state_q == StIdle);
`endif

   always_comb begin
      state_d    = state_q;
      edge_cnt_d = edge_cnt_q + 6'd1;
      bit_cnt_d  = bit_cnt_q;
      data_d     = data_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      presc_d    = presc_q;
      done_d     = 1'b0;
      start_in   = 1'b0;
      start_buf  = 1'b0;
      tx_d       = 1'b1;

      case (state_q)
         StIdle: begin
            edge_cnt_d = '0;
            start_in   = accept;
         end
         StStart: begin
            if (bit_end) begin
               state_d    = StData;
               edge_cnt_d = '0;
               bit_cnt_d  = '0;
            end
         end
         StData: begin
            if (bit_end) begin
               edge_cnt_d = '0;
               if (bit_cnt_q == LastBit) begin
                  state_d = par_en_q ? StParity : StStop;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         StParity: begin
            if (bit_end) begin
               state_d    = StStop;
               edge_cnt_d = '0;
            end
         end
         StStop: begin
            if (bit_end) begin
               done_d     = 1'b1;
               edge_cnt_d = '0;
               state_d    = StIdle;
`ifdef UART_TX_HOLD_BUF_EN
               start_buf  = buf_full_q;
               start_in   = accept && !buf_full_q;
`endif
            end
         end
         default: state_d = StIdle;
      endcase

      if (start_in || start_buf) begin
         state_d    = StStart;
         edge_cnt_d = '0;
         bit_cnt_d  = '0;
      end
      if (start_in) begin
         data_d    = P_DATA;
         par_en_d  = PAR_EN;
         par_typ_d = PAR_TYP;
         presc_d   = presc_in;
      end

`ifdef UART_TX_HOLD_BUF_EN
      buf_full_d    = buf_full_q;
      buf_data_d    = buf_data_q;
      buf_par_en_d  = buf_par_en_q;
      buf_par_typ_d = buf_par_typ_q;
      buf_presc_d   = buf_presc_q;
      if (start_buf) begin
         data_d     = buf_data_q;
         par_en_d   = buf_par_en_q;
         par_typ_d  = buf_par_typ_q;
         presc_d    = buf_presc_q;
         buf_full_d = 1'b0;
      end
      // A word accepted on the drain edge refills the buffer.
      if (accept && !start_in) begin
         buf_full_d    = 1'b1;
         buf_data_d    = P_DATA;
         buf_par_en_d  = PAR_EN;
         buf_par_typ_d = PAR_TYP;
         buf_presc_d   = presc_in;
      end
`endif

      // Line level is registered, so it is decoded from the next state.
      case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = data_d[bit_cnt_d];
         StParity: tx_d = (^data_d) ^ par_typ_d;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= StIdle;
         edge_cnt_q <= '0;
         bit_cnt_q  <= '0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         presc_q    <= 6'd4;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         edge_cnt_q <= edge_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         data_q     <= data_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         presc_q    <= presc_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
      end
   end

`ifdef UART_TX_HOLD_BUF_EN
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         buf_full_q    <= 1'b0;
         buf_data_q    <= '0;
         buf_par_en_q  <= 1'b0;
         buf_par_typ_q <= 1'b0;
         buf_presc_q   <= 6'd4;
      end else begin
         buf_full_q    <= buf_full_d;
         buf_data_q    <= buf_data_d;
         buf_par_en_q  <= buf_par_en_d;
         buf_par_typ_q <= buf_par_typ_d;
         buf_presc_q   <= buf_presc_d;
      end
   end
`endif

   assign TX_OUT     = tx_q;
   assign busy       = (state_q != StIdle);
   assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed words with hand-written expected line patterns,
// checked by a scoreboard monitor that follows the serial line.
module tb_uart_tx_frame;
   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] P_DATA = '0;
   logic       DATA_VALID = 1'b0;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [5:0] prescale = 6'd8;
   logic       TX_READY, TX_OUT, busy, frame_done;

   uart_tx_frame #(.WIDTH(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .prescale   (prescale),
      .TX_READY   (TX_READY),
      .TX_OUT     (TX_OUT),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 CLK = ~CLK;

   // bits[i] is the i-th symbol on the line; gap/post_busy < 0 means don't care.
   typedef struct {
      logic [11:0] bits;
      int          n;
      int          presc;
      int          gap;
      int          post_busy;
   } frame_t;

   frame_t q[$];
   int     checks = 0;
   int     failures = 0;
   bit     mon_en = 1'b1;
   bit     mon_busy = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic frame_t mk(input logic [11:0] bits, input int n, input int presc,
                                 input int gap, input int post_busy);
      frame_t f;
      f.bits = bits; f.n = n; f.presc = presc; f.gap = gap; f.post_busy = post_busy;
      return f;
   endfunction

   task automatic monitor();
      int idle_cnt = 0;
      int fidx = 0;
      frame_t f;
      @(negedge CLK);
      forever begin
         if (mon_en && RST && TX_OUT === 1'b0) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_frame: start bit seen with no word outstanding");
               for (int g = 0; g < 2000 && busy; g++) @(negedge CLK);
               idle_cnt = 0;
               @(negedge CLK);
            end else begin
               f = q.pop_front();
               mon_busy = 1'b1;
               if (f.gap >= 0) chk($sformatf("frame%0d_idle_gap", fidx), idle_cnt, f.gap);
               for (int b = 0; b < f.n; b++) begin
                  automatic int bad = 0;
                  for (int c = 0; c < f.presc; c++) begin
                     if (b != 0 || c != 0) @(negedge CLK);
                     if (TX_OUT !== f.bits[b] || busy !== 1'b1) bad++;
                     if ((b != 0 || c != 0) && frame_done !== 1'b0) bad++;
                  end
                  chk($sformatf("frame%0d_bit%0d_bad_cycles", fidx, b), bad, 0);
               end
               @(negedge CLK);
               chk($sformatf("frame%0d_done_pulse", fidx), int'(frame_done), 1);
               if (f.post_busy >= 0)
                  chk($sformatf("frame%0d_busy_after", fidx), int'(busy), f.post_busy);
               idle_cnt = 0;
               fidx++;
               mon_busy = 1'b0;
            end
         end else begin
            idle_cnt++;
            @(negedge CLK);
         end
      end
   endtask

   initial monitor();

   task automatic send(input logic [7:0] d, input logic pen, input logic ptyp,
                       input logic [5:0] ps, input frame_t exp);
      int guard = 0;
      @(negedge CLK);
      P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; prescale = ps; DATA_VALID = 1'b1;
      while (!TX_READY && guard < 2000) begin
         @(negedge CLK);
         guard++;
      end
      if (!TX_READY) begin
         chk("send_ready_timeout", 0, 1);
         DATA_VALID = 1'b0;
         return;
      end
      if (exp.n > 0) q.push_back(exp);
      @(posedge CLK);
      #1;
      // Scramble inputs to show the frame uses captured values.
      DATA_VALID = 1'b0; P_DATA = ~d; PAR_EN = ~pen; PAR_TYP = ~ptyp; prescale = 6'd1;
   endtask

   task automatic wait_idle();
      int guard = 0;
      while ((q.size() != 0 || mon_busy) && guard < 5000) begin
         @(negedge CLK);
         guard++;
      end
      if (guard >= 5000) chk("drain_timeout", 0, 1);
      repeat (3) @(negedge CLK);
   endtask

   initial begin
      frame_t none;
      none = mk(12'h0, 0, 0, -1, -1);
      repeat (3) @(negedge CLK);
      chk("reset_tx_out", int'(TX_OUT), 1);
      chk("reset_busy", int'(busy), 0);
      chk("reset_tx_ready", int'(TX_READY), 1);
      chk("reset_frame_done", int'(frame_done), 0);
      RST = 1'b1;
      repeat (2) @(negedge CLK);

      // 0xA5, even parity -> parity 0, 8 cycles per bit
      send(8'hA5, 1'b1, 1'b0, 6'd8, mk(12'b0_1_0_10100101_0, 11, 8, -1, 0));
      wait_idle();
      // 0x01 odd -> parity 0; 0x01 even -> parity 1
      send(8'h01, 1'b1, 1'b1, 6'd16, mk(12'b0_1_0_00000001_0, 11, 16, -1, 0));
      wait_idle();
      send(8'h01, 1'b1, 1'b0, 6'd16, mk(12'b0_1_1_00000001_0, 11, 16, -1, 0));
      wait_idle();
      // no parity: stop right after bit 7
      send(8'hFF, 1'b0, 1'b0, 6'd16, mk(12'b00_1_11111111_0, 10, 16, -1, 0));
      wait_idle();

`ifdef UART_TX_HOLD_BUF_EN
      send(8'h11, 1'b0, 1'b0, 6'd4, mk(12'b00_1_00010001_0, 10, 4, -1, 1));
      send(8'h22, 1'b0, 1'b0, 6'd4, mk(12'b00_1_00100010_0, 10, 4, 0, 0));
      chk("buf_full_tx_ready", int'(TX_READY), 0);
      begin
         int guard = 0;
         while (!TX_READY && guard < 200) begin
            @(negedge CLK);
            guard++;
         end
         chk("buf_drain_tx_ready", int'(TX_READY), 1);
         chk("buf_drain_busy", int'(busy), 1);
      end
      wait_idle();
`else
      send(8'h5A, 1'b0, 1'b0, 6'd4, mk(12'b00_1_01011010_0, 10, 4, -1, 0));
      repeat (4) @(negedge CLK);
      P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0; prescale = 6'd4; DATA_VALID = 1'b1;
      begin
         automatic int rdy = 0;
         repeat (10) begin
            @(negedge CLK);
            if (TX_READY !== 1'b0) rdy++;
         end
         chk("busy_tx_ready_low_cycles", rdy, 0);
      end
      DATA_VALID = 1'b0;
      wait_idle();
      repeat (10) @(negedge CLK);
      chk("idle_tx_ready", int'(TX_READY), 1);
      chk("idle_line_high", int'(TX_OUT), 1);
      // prescale 2 clamps to 4; 0x3C even -> parity 0
      send(8'h3C, 1'b1, 1'b0, 6'd2, mk(12'b0_1_0_00111100_0, 11, 4, -1, 0));
      wait_idle();
`endif

      // Asynchronous reset in the middle of the data bits.
      mon_en = 1'b0;
      send(8'hC3, 1'b1, 1'b0, 6'd4, none);
      repeat (12) @(negedge CLK);
      #2;
      RST = 1'b0;
      #1;
      chk("midreset_tx_out", int'(TX_OUT), 1);
      chk("midreset_busy", int'(busy), 0);
      chk("midreset_tx_ready", int'(TX_READY), 1);
      chk("midreset_frame_done", int'(frame_done), 0);
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      mon_en = 1'b1;
      // 0x96 odd -> parity 1, prescale 5
      send(8'h96, 1'b1, 1'b1, 6'd5, mk(12'b0_1_1_10010110_0, 11, 5, -1, 0));
      wait_idle();
      repeat (20) @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
